// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer plus a four-state
// stability FSM per channel, producing a clean level and a one-cycle press strobe.
module button_debouncer #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_BUTTONS-1:0] BUTTONS_RAW,
    output logic [N_BUTTONS-1:0] BUTTONS_LEVEL,
    output logic [N_BUTTONS-1:0] BUTTONS_PULSE
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
            logic                 r_s1;
            logic                 r_s2;
            state_t               r_state;
            state_t               w_state_next;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [CNT_WIDTH-1:0] w_cnt_next;
            logic                 r_level;
            logic                 r_pulse;
            logic                 w_level_next;
            logic                 w_pulse_next;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= BUTTONS_RAW[gi];
                    r_s2 <= r_s1;
                end
            end

            // Counter only advances while waiting; every wait entry clears it.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    RELEASED: begin
                        if (r_s2) begin
                            w_state_next = PRESS_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!r_s2) begin
                            w_state_next = RELEASED;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_LAST) begin
                            w_state_next = PRESSED;
                        end else begin
                            w_cnt_next = r_cnt + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!r_s2) begin
                            w_state_next = RELEASE_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (r_s2) begin
                            w_state_next = PRESSED;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_LAST) begin
                            w_state_next = RELEASED;
                        end else begin
                            w_cnt_next = r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_next = RELEASED;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Outputs are registered from the next state so they line up with it.
            always_comb begin
                w_level_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);
                w_pulse_next = (r_state == PRESS_WAIT) && (w_state_next == PRESSED);
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_level <= w_level_next;
                    r_pulse <= w_pulse_next;
                end
            end

            assign BUTTONS_LEVEL[gi] = r_level;
            assign BUTTONS_PULSE[gi] = r_pulse;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed expectations at fixed edges.
module tb_button_debouncer;
    localparam int N = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] level;
    logic [N-1:0] pulse;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int base     = 0;
    int p1cnt    = 0;
    bit started  = 1'b0;

    button_debouncer #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      ($clog2(D))
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .BUTTONS_RAW  (raw),
        .BUTTONS_LEVEL(level),
        .BUTTONS_PULSE(pulse)
    );

    always #5 clk = ~clk;

    // Reference: the level seen by the debouncer is raw delayed two edges; the
    // accepted level flips once D+1 consecutive samples disagree with it.
    logic [N-1:0] d1 = '0, d2 = '0, m_level = '0, m_pulse = '0;
    int run[N];

    always @(posedge clk) begin
        logic [N-1:0] nl;
        logic [N-1:0] np;
        int nr;
        edge_cnt <= edge_cnt + 1;
        if (rst) begin
            d1      <= '0;
            d2      <= '0;
            m_level <= '0;
            m_pulse <= '0;
            for (int i = 0; i < N; i++) run[i] <= 0;
        end else begin
            nl = m_level;
            np = '0;
            for (int i = 0; i < N; i++) begin
                if (d2[i] != m_level[i]) begin
                    nr = run[i] + 1;
                    if (nr == D + 1) begin
                        nl[i] = d2[i];
                        np[i] = d2[i];
                        nr    = 0;
                    end
                end else begin
                    nr = 0;
                end
                run[i] <= nr;
            end
            m_level <= nl;
            m_pulse <= np;
            d2      <= d1;
            d1      <= raw;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (level !== m_level || pulse !== m_pulse) begin
                errors++;
                $display("FAIL model_cycle edge %0d: level %b pulse %b, expected level %b pulse %b",
                         edge_cnt - base, level, pulse, m_level, m_pulse);
            end
            if (pulse[1] === 1'b1) p1cnt++;
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Returns just after relative edge n (edge 0 is the reset edge).
    task automatic go_edge(input int n);
        while (edge_cnt < base + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        raw = '0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        base    = edge_cnt;
        started = 1'b1;
    endtask

    logic [7:0] bounce_seq = 8'b00101101;  // edges 12..19, LSB first: 1,0,1,1,0,1,0,0

    initial begin
        do_reset();
        chk("reset_level", level, 3'b000);
        chk("reset_pulse", pulse, 3'b000);

        // Clean press on channel 0 from edge 10
        go_edge(9);  raw = 3'b001;
        go_edge(15); chk("clean_l15", level, 3'b000); chk("clean_p15", pulse, 3'b000);
        go_edge(16); chk("clean_l16", level, 3'b001); chk("clean_p16", pulse, 3'b001);
        go_edge(17); chk("clean_l17", level, 3'b001); chk("clean_p17", pulse, 3'b000);
        go_edge(40); chk("clean_hold", level, 3'b001);

        // Bounce on channel 1, steady high from edge 20
        do_reset();
        p1cnt = 0;
        for (int j = 0; j < 8; j++) begin
            go_edge(11 + j);
            raw[1] = bounce_seq[j];
        end
        go_edge(19); raw[1] = 1'b1;
        go_edge(25); chk("bounce_p25", pulse, 3'b000);
        go_edge(26); chk("bounce_p26", pulse, 3'b010); chk("bounce_l26", level, 3'b010);
        go_edge(27); chk("bounce_p27", pulse, 3'b000);
        go_edge(45); chk("bounce_count", 3'(p1cnt), 3'd1);

        // Release glitch on channel 0, then a real release
        do_reset();
        go_edge(1);  raw = 3'b001;
        go_edge(8);  chk("glitch_press", pulse, 3'b001);
        go_edge(11); raw = 3'b000;
        go_edge(13); raw = 3'b001;
        for (int e = 14; e <= 22; e++) begin
            go_edge(e);
            chk("glitch_level", level, 3'b001);
            chk("glitch_pulse", pulse, 3'b000);
        end
        go_edge(24); raw = 3'b000;
        go_edge(30); chk("release_l30", level, 3'b001);
        go_edge(31); chk("release_l31", level, 3'b000); chk("release_p31", pulse, 3'b000);

        // Simultaneous press on all channels from edge 5
        do_reset();
        go_edge(4);  raw = 3'b111;
        go_edge(10); chk("simul_p10", pulse, 3'b000);
        go_edge(11); chk("simul_p11", pulse, 3'b111); chk("simul_l11", level, 3'b111);
        go_edge(12); chk("simul_p12", pulse, 3'b000);

        // Reset at edge 14: ch1 pulse due then is dropped, ch2 in PRESS_WAIT
        do_reset();
        go_edge(7);  raw = 3'b010;
        go_edge(9);  raw = 3'b110;
        go_edge(13); rst = 1'b1;
        go_edge(14); rst = 1'b0;
        chk("rst_l14", level, 3'b000); chk("rst_p14", pulse, 3'b000);
        go_edge(16); chk("rst_p16", pulse, 3'b000);
        go_edge(20); chk("rst_p20", pulse, 3'b000);
        go_edge(21); chk("rst_p21", pulse, 3'b110); chk("rst_l21", level, 3'b110);
        go_edge(22); chk("rst_p22", pulse, 3'b000);
        go_edge(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 3, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES), width of each channel's stability counter.
REQ-004 CLK  input  1  system clock; all state updates on the rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 BUTTONS_RAW  input  N_BUTTONS  asynchronous, bouncing push-button levels from the board.
REQ-007 BUTTONS_LEVEL  output  N_BUTTONS  registered debounced level per channel.
REQ-008 BUTTONS_PULSE  output  N_BUTTONS  registered single-cycle strobe per accepted press; drives the BUTTONS load-enable input of the downstream ALU top level.

Function
REQ-009 Each channel SHALL pass BUTTONS_RAW[i] through a two-flop synchronizer (S1, S2); only S2 feeds the channel FSM.
REQ-010 Channels SHALL be fully independent: separate synchronizer, FSM, counter and outputs, with no shared state.
REQ-011 Each channel FSM SHALL have exactly four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 In RELEASED: S2=1 -> PRESS_WAIT with counter cleared to 0; S2=0 -> remain.
REQ-013 In PRESS_WAIT: S2=0 -> RELEASED with counter cleared; S2=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-014 In PRESSED: S2=0 -> RELEASE_WAIT with counter cleared; S2=1 -> remain.
REQ-015 In RELEASE_WAIT: S2=1 -> PRESSED with counter cleared and no new pulse; S2=0 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter increments.
REQ-016 BUTTONS_LEVEL[i] SHALL be 1 exactly while the channel is in PRESSED or RELEASE_WAIT.
REQ-017 BUTTONS_PULSE[i] SHALL be 1 for exactly one cycle: the cycle after the PRESS_WAIT -> PRESSED transition edge, i.e. coincident with the first cycle of BUTTONS_LEVEL[i]=1.
REQ-018 Latency: raw going 1 and held, first sampled at edge k -> LEVEL and PULSE high after edge k+2+DEBOUNCE_CYCLES; release is symmetric for LEVEL going 0, with no pulse.
REQ-019 A raw high lasting fewer than DEBOUNCE_CYCLES consecutive S2 samples SHALL produce no pulse and no LEVEL change.
REQ-020 A button held indefinitely SHALL produce exactly one pulse; re-triggering requires an accepted release (RELEASED) followed by an accepted press.
REQ-021 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 Simultaneous accepted presses on several channels SHALL assert their PULSE bits in the same cycle.

Reset
REQ-023 While RESET=1 at a rising edge: S1, S2, counters = 0; all FSMs = RELEASED; BUTTONS_LEVEL = 0; BUTTONS_PULSE = 0.
REQ-024 Reset SHALL override all other activity, including a transition or pulse due in the same cycle; no pulse SHALL be emitted from a press in progress when reset asserts.
REQ-025 After reset deassertion with a button still held, the channel SHALL re-debounce from RELEASED and emit one fresh pulse after the REQ-018 latency.

Verification (DEBOUNCE_CYCLES=4, N_BUTTONS=3)
REQ-026 Clean press: RAW=3'b001 from edge 10, held -> LEVEL=3'b001 and PULSE=3'b001 after edge 16; PULSE=0 after edge 17; LEVEL stays 1 while held.
REQ-027 Bounce: RAW[1] toggles 1,0,1,1,0,1 on consecutive edges, then holds 1 from edge 20 -> no pulse during the toggling; exactly one PULSE[1] after edge 26.
REQ-028 Release glitch: channel 0 in PRESSED, RAW[0]=0 for 2 cycles then 1 -> LEVEL[0] stays 1 throughout, no additional pulse.
REQ-029 Simultaneous: RAW=3'b111 from edge 5 -> PULSE=3'b111 for one cycle after edge 11.
REQ-030 Reset mid-operation: RESET=1 for one cycle at edge 14 during PRESS_WAIT of channel 2 with RAW[2] held -> no pulse at edge 16; outputs 0 after edge 14; single PULSE[2] after edge 21.
